jtag_dbg_responder: RTL

- CPU-clock-domain end of the LM32 JTAG debug register path.
- Consumes the byte and address that the JTAG side writes through `reg_update`/`reg_q`/`reg_addr_q`, and decodes them as debug commands.
- Executes single-word memory reads and writes over a simple strobe/ack master port.
- Returns status and response bytes to the JTAG side on `reg_d`/`reg_addr_d`.
- Sits beside the processor; its `reg_*` ports connect directly to the JTAG core wrapper.

---
 rtl/jtag_dbg_responder_pkg.sv | 35 +++
 rtl/jtag_dbg_responder_update_sync.sv | 27 ++
 rtl/jtag_dbg_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_dbg_responder_pkg.sv
// Shared opcodes, FSM encoding and status-bit indices for the LM32 JTAG debug responder.
// The S_RXB state only exists when JTAG_UART_EN is defined.
package jtag_dbg_responder_pkg;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_READ       = 4'h1;
  localparam logic [3:0] OP_WRITE      = 4'h2;
  localparam logic [3:0] OP_READ_NEXT  = 4'h3;
  localparam logic [3:0] OP_WRITE_NEXT = 4'h4;
  localparam logic [3:0] OP_RX         = 4'h5;
  localparam logic [3:0] OP_BREAK      = 4'h6;
  localparam logic [3:0] OP_POP        = 4'h7;
  localparam logic [3:0] OP_CLR        = 4'h8;

  localparam int ST_ERR  = 2;
  localparam int ST_BUSY = 1;
  localparam int ST_RVLD = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REQ  = 3'd3,
    S_RESP = 3'd4
`ifdef JTAG_UART_EN
    , S_RXB = 3'd5
`endif
  } state_t;

  // The _NEXT commands step from the word-aligned last address; the sum wraps at 2^32.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00} + 32'd4;
  endfunction

endpackage

// File: rtl/jtag_dbg_responder_update_sync.sv
// Two-flop synchronizer for the JTAG-domain update level, plus a one-cycle rising-edge pulse.
module jtag_update_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic meta;
  logic sync;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= async_i;
      sync   <= meta;
      sync_q <= sync;
    end
  end

  assign rise_o = sync & ~sync_q;

endmodule

// File: rtl/jtag_dbg_responder.sv
// CPU-side end of the LM32 JTAG debug path: decodes JTAG bytes into memory accesses and pulses.
// Optional host-to-CPU byte channel (opcode 0x5) is built only when JTAG_UART_EN is defined.
module jtag_dbg_responder
  import jtag_dbg_responder_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_update,
  input  logic [7:0]  reg_q,
  input  logic [2:0]  reg_addr_q,
  output logic [7:0]  reg_d,
  output logic [2:0]  reg_addr_d,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic        mem_we_o,
  output logic        mem_stb_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  output logic [7:0]  jrx_dat_o,
  output logic        jrx_vld_o,
  output logic        break_o
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  state_t state, state_d;

  logic        upd_rise;
  logic        byte_ok;
  logic [3:0]  opcode;

  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [31:0] rbuf;
  logic        we_r;
  logic        err_r;
  logic        rvld_r;
  logic [1:0]  pop_cnt;
  logic [1:0]  bcnt;
  logic [TW-1:0] tmr;
  logic        brk_r;

  logic addr_shift, addr_next, data_shift, cnt_clr, tmr_clr;
  logic set_we, clr_we, rd_load, pop, clr, set_err, brk;
`ifdef JTAG_UART_EN
  logic       rx_emit;
  logic [7:0] jrx_dat_r;
  logic       jrx_vld_r;
`endif

  jtag_update_sync u_update_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(reg_update),
    .rise_o (upd_rise)
  );

  assign byte_ok = upd_rise & (reg_addr_q == 3'd0);
  assign opcode  = reg_q[7:4];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    addr_shift = 1'b0;
    addr_next  = 1'b0;
    data_shift = 1'b0;
    cnt_clr    = 1'b0;
    tmr_clr    = 1'b0;
    set_we     = 1'b0;
    clr_we     = 1'b0;
    rd_load    = 1'b0;
    pop        = 1'b0;
    clr        = 1'b0;
    set_err    = 1'b0;
    brk        = 1'b0;
`ifdef JTAG_UART_EN
    rx_emit    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (byte_ok) begin
          case (opcode)
            OP_READ:       begin state_d = S_ADDR; cnt_clr = 1'b1; clr_we = 1'b1; end
            OP_WRITE:      begin state_d = S_ADDR; cnt_clr = 1'b1; set_we = 1'b1; end
            OP_READ_NEXT:  begin state_d = S_REQ;  addr_next = 1'b1; clr_we = 1'b1; tmr_clr = 1'b1; end
            OP_WRITE_NEXT: begin state_d = S_DATA; addr_next = 1'b1; set_we = 1'b1; cnt_clr = 1'b1; end
`ifdef JTAG_UART_EN
            OP_RX:         state_d = S_RXB;
`endif
            OP_BREAK:      brk = 1'b1;
            OP_POP:        pop = 1'b1;
            OP_CLR:        clr = 1'b1;
            default:       ;
          endcase
        end
      end
      S_ADDR: begin
        if (byte_ok) begin
          addr_shift = 1'b1;
          if (bcnt == 2'd3) begin
            if (we_r) begin
              state_d = S_DATA;
            end else begin
              state_d = S_REQ;
              tmr_clr = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        if (byte_ok) begin
          data_shift = 1'b1;
          if (bcnt == 2'd3) begin
            state_d = S_REQ;
            tmr_clr = 1'b1;
          end
        end
      end
`ifdef JTAG_UART_EN
      S_RXB: begin
        if (byte_ok) begin
          rx_emit = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      S_REQ: begin
        // Ack wins over a timeout landing on the same cycle; stray bytes here are lost.
        if (byte_ok) set_err = 1'b1;
        if (mem_ack_i) begin
          state_d = S_IDLE;
          rd_load = ~we_r;
        end else if (tmr == TMR_LAST) begin
          state_d = S_IDLE;
          set_err = 1'b1;
        end
      end
      // Read completion loads the buffer straight from REQ, so RESP is only a safe exit.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_r  <= '0;
      data_r  <= '0;
      rbuf    <= '0;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      rvld_r  <= 1'b0;
      pop_cnt <= '0;
      bcnt    <= '0;
      tmr     <= '0;
      brk_r   <= 1'b0;
    end else begin
      brk_r <= brk;

      if (addr_shift)     addr_r <= {addr_r[23:0], reg_q};
      else if (addr_next) addr_r <= next_word_addr(addr_r);

      if (data_shift) data_r <= {data_r[23:0], reg_q};

      if (set_we)      we_r <= 1'b1;
      else if (clr_we) we_r <= 1'b0;

      if (cnt_clr)                       bcnt <= '0;
      else if (addr_shift || data_shift) bcnt <= bcnt + 2'd1;

      if (tmr_clr)             tmr <= '0;
      else if (state == S_REQ) tmr <= tmr + TW'(1);

      if (set_err)  err_r <= 1'b1;
      else if (clr) err_r <= 1'b0;

      if (clr) begin
        rbuf    <= '0;
        rvld_r  <= 1'b0;
        pop_cnt <= '0;
      end else if (rd_load) begin
        rbuf    <= mem_dat_i;
        rvld_r  <= 1'b1;
        pop_cnt <= '0;
      end else if (pop && rvld_r) begin
        rbuf    <= {rbuf[23:0], 8'h00};
        pop_cnt <= pop_cnt + 2'd1;
        if (pop_cnt == 2'd3) rvld_r <= 1'b0;
      end
    end
  end

`ifdef JTAG_UART_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      jrx_dat_r <= '0;
      jrx_vld_r <= 1'b0;
    end else begin
      jrx_vld_r <= rx_emit;
      if (rx_emit) jrx_dat_r <= reg_q;
    end
  end

  assign jrx_dat_o = jrx_dat_r;
  assign jrx_vld_o = jrx_vld_r;
`else
  assign jrx_dat_o = 8'h00;
  assign jrx_vld_o = 1'b0;
`endif

  assign mem_stb_o  = (state == S_REQ);
  assign mem_we_o   = we_r & mem_stb_o;
  assign mem_adr_o  = {addr_r[31:2], 2'b00};
  assign mem_dat_o  = data_r;
  assign reg_d      = rbuf[31:24];
  assign break_o    = brk_r;

  assign reg_addr_d[ST_ERR]  = err_r;
  assign reg_addr_d[ST_BUSY] = (state != S_IDLE);
  assign reg_addr_d[ST_RVLD] = rvld_r;

endmodule
